seq_bit_serializer: RTL and testbench
=====================================

SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of data bits per input word (legal range 2..32).
REQ-002 The block SHALL have parameter IDLE_BIT, default 0, giving the level driven on bit_out when no bit is valid.
REQ-003 The block SHALL have port clk  input  1  clock; all logic is rising-edge triggered.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_data  input  WIDTH  word to serialize.
REQ-006 The block SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-007 The block SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-008 The block SHALL have port bit_out  output  1  serial bit, MSB first; it drives the downstream detector's input bit.
REQ-009 The block SHALL have port bit_valid  output  1  bit_out carries a data or parity bit this cycle.
REQ-010 The block SHALL have port frame_start  output  1  high for exactly the cycle carrying a word's MSB.
REQ-011 The block SHALL have port busy  output  1  high while the shifter or the holding register is occupied.

Function
REQ-012 The block SHALL contain one WIDTH-bit holding register (with hold_valid flag) and one shift register (with shift_valid flag).
REQ-013 in_ready SHALL equal !hold_valid, decoded from registers only, with no combinational path from in_valid.
REQ-014 A word SHALL be accepted at a rising edge where in_valid && in_ready; it is then written to the holding register.
REQ-015 The shifter FSM SHALL have states IDLE and SHIFT, plus PARITY when SER_PARITY_EN is defined.
REQ-016 IDLE -> SHIFT SHALL occur at the edge where hold_valid=1; the word moves into the shifter and hold_valid clears at that same edge.
REQ-017 In SHIFT, bit_out SHALL present bit WIDTH-1-k of the word during bit count k (k=0..WIDTH-1); bit_valid=1.
REQ-018 bit_out, bit_valid and frame_start SHALL be registered outputs.
REQ-019 Latency: a word accepted at edge N into an idle block SHALL drive its MSB on bit_out in the cycle after edge N+1.
REQ-020 After the final bit of a word, if hold_valid=1, the next word SHALL load with zero gap cycles; otherwise the FSM SHALL return to IDLE.
REQ-021 Simultaneous accept and transfer SHALL be supported: at the edge where the holding register empties into the shifter, in_ready is already low, so no same-edge refill occurs; refill occurs on the next edge.
REQ-022 Sustained input at 1 word per WIDTH cycles SHALL produce a contiguous bit_valid stream.
REQ-023 When bit_valid=0, bit_out SHALL equal IDLE_BIT and frame_start SHALL be 0.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL wrap to 0 on word completion.
REQ-025 busy SHALL equal hold_valid || shift_valid.

Reset
REQ-026 On reset, the FSM SHALL go to IDLE and hold_valid, shift_valid, bit_valid and frame_start SHALL be 0.
REQ-027 On reset, bit_out SHALL be IDLE_BIT, in_ready SHALL be 1 from the first cycle after reset, and busy SHALL be 0.
REQ-028 Reset asserted mid-word SHALL discard the partial word and any held word, with no further bits emitted.
REQ-029 Reset SHALL take priority over an accept in the same cycle; the word is dropped.

Configuration
REQ-030 Macro SER_PARITY_EN defined: after the LSB, the block SHALL emit one PARITY-state bit equal to the XOR of the WIDTH data bits (even parity), with bit_valid=1; each frame is then WIDTH+1 cycles.
REQ-031 Macro SER_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and each frame is WIDTH cycles.

Verification
REQ-032 Default parameters, send 8'hB0 into an idle block: bit_out SHALL be 1,0,1,1,0,0,0,0 on 8 consecutive bit_valid cycles, frame_start SHALL be high on the first of them only, and the downstream 1011 detector SHALL flag the sequence.
REQ-033 Send 8'hA5 then 8'h3C with in_valid held high: 16 contiguous bit_valid cycles SHALL carry 1010010100111100, and in_ready SHALL be low while the holding register is full.
REQ-034 Send 8'hFF, then assert reset after the 3rd bit: bit_valid SHALL be 0 and bit_out SHALL be 0 from the next cycle, and busy SHALL be 0.
REQ-035 With SER_PARITY_EN defined, send 8'hB0: 9 bits SHALL be emitted, 101100001, with the final parity bit = 1.
REQ-036 Hold in_valid low for 20 cycles after reset: bit_valid SHALL stay 0, bit_out SHALL stay at IDLE_BIT, and in_ready SHALL stay 1.

Source files
------------

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer: one holding register feeding a shift register, MSB first.
// Optional even-parity bit after each word when SER_PARITY_EN is defined.
module seq_bit_serializer #(
  parameter int WIDTH    = 8,
  parameter bit IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hold_data_q;
  logic               hold_valid_q;
  logic [WIDTH-1:0]   shift_data_q, shift_data_d;
  logic               shift_valid_q, shift_valid_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               bit_out_q, bit_out_d;
  logic               bit_valid_q, bit_valid_d;
  logic               frame_start_q, frame_start_d;
  logic               load;
  logic               accept;
`ifdef SER_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // Ready comes only from the holding flag, so in_valid never reaches in_ready.
  assign in_ready = !hold_valid_q;
  assign accept   = in_valid && !hold_valid_q;
  assign busy     = hold_valid_q || shift_valid_q;

  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;

  // Holding register: a transfer and an accept can never share an edge,
  // because a transfer needs hold_valid set, which blocks accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
    end else if (load) begin
      hold_valid_q <= 1'b0;
    end else if (accept) begin
      hold_valid_q <= 1'b1;
    end
  end

  // NOTE: data-only registers are qualified by their valid flags, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data_q <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shift_valid_q <= 1'b0;
      bit_cnt_q     <= '0;
      bit_out_q     <= IDLE_BIT;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_valid_q <= shift_valid_d;
      bit_cnt_q     <= bit_cnt_d;
      bit_out_q     <= bit_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_data_q <= shift_data_d;
`ifdef SER_PARITY_EN
    parity_q     <= parity_d;
`endif
  end

  // Next-state logic computes the value each output register will show
  // during the following cycle; an idle cycle falls through to IDLE_BIT.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d       = state_q;
    shift_data_d  = shift_data_q;
    shift_valid_d = shift_valid_q;
    bit_cnt_d     = bit_cnt_q;
    bit_out_d     = IDLE_BIT;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    load          = 1'b0;
`ifdef SER_PARITY_EN
    parity_d      = parity_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (hold_valid_q) begin
          load = 1'b1;
        end
      end

      S_SHIFT: begin
        if (bit_cnt_q == LAST_CNT) begin
          bit_cnt_d = '0;
`ifdef SER_PARITY_EN
          state_d     = S_PARITY;
          bit_out_d   = parity_q;
          bit_valid_d = 1'b1;
`else
          if (hold_valid_q) begin
            load = 1'b1;
          end else begin
            state_d       = S_IDLE;
            shift_valid_d = 1'b0;
          end
`endif
        end else begin
          bit_cnt_d    = bit_cnt_q + 1'b1;
          shift_data_d = shift_data_q << 1;
          bit_out_d    = shift_data_q[WIDTH-2];
          bit_valid_d  = 1'b1;
        end
      end

`ifdef SER_PARITY_EN
      S_PARITY: begin
        if (hold_valid_q) begin
          load = 1'b1;
        end else begin
          state_d       = S_IDLE;
          shift_valid_d = 1'b0;
        end
      end
`endif

      default: begin
        state_d       = S_IDLE;
        shift_valid_d = 1'b0;
      end
    endcase

    // Loading a word presents its MSB on the very edge it enters the shifter.
    if (load) begin
      state_d       = S_SHIFT;
      shift_data_d  = hold_data_q;
      shift_valid_d = 1'b1;
      bit_cnt_d     = '0;
      bit_out_d     = hold_data_q[WIDTH-1];
      bit_valid_d   = 1'b1;
      frame_start_d = 1'b1;
`ifdef SER_PARITY_EN
      parity_d      = ^hold_data_q;
`endif
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: expected bits are queued on accept and
// popped at each bit_valid cycle; also models a downstream 1011 detector.
module tb_seq_bit_serializer;

  localparam int WIDTH    = 8;
  localparam bit IDLE_BIT = 1'b0;
`ifdef SER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef struct {
    logic b;
    logic fs;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             bit_out;
  logic             bit_valid;
  logic             frame_start;
  logic             busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t e_mon;
  int   run_len = 0;
  int   max_run = 0;
  int   bits_seen = 0;
  logic [3:0] hist = '0;
  logic det_hit = 1'b0;

  seq_bit_serializer #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      exp_q.push_back('{b: d[i], fs: (i == WIDTH - 1)});
    end
`ifdef SER_PARITY_EN
    exp_q.push_back('{b: ^d, fs: 1'b0});
`endif
  endtask

  // Leaves in_valid high on return so back-to-back calls keep the input streaming.
  task automatic send(input logic [WIDTH-1:0] d);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    forever begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        push_word(d);
        break;
      end
      n++;
      if (n > 4 * FRAME) begin
        check("send_timeout", in_ready, 1);
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 || busy) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 8 * FRAME) begin
        check("drain_timeout", busy, 0);
        break;
      end
    end
  endtask

  task automatic clear_stats();
    max_run   = 0;
    bits_seen = 0;
    hist      = '0;
    det_hit   = 1'b0;
  endtask

  // Output monitor: compares every bit against the scoreboard, checks idle levels,
  // tracks contiguous runs and a 1011 pattern detector.
  always @(negedge clk) begin
    if (!reset) begin
      if (bit_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        bits_seen++;
        hist = {hist[2:0], bit_out};
        if (hist == 4'b1011) det_hit = 1'b1;
        if (exp_q.size() == 0) begin
          check("sb_extra_bit", bit_valid, 0);
        end else begin
          e_mon = exp_q.pop_front();
          check("sb_bit", bit_out, e_mon.b);
          check("sb_frame_start", frame_start, e_mon.fs);
        end
      end else begin
        run_len = 0;
        check("idle_bit_out", bit_out, IDLE_BIT);
        check("idle_frame_start", frame_start, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_bit_out", bit_out, IDLE_BIT);
    check("rst_frame_start", frame_start, 0);

    // Idle for 20 cycles
    repeat (20) begin
      @(posedge clk);
      #1;
      check("idle_in_ready", in_ready, 1);
      check("idle_bit_valid", bit_valid, 0);
    end

    // Single word B0 into idle block: latency, frame, detector
    clear_stats();
    send(8'hB0);
    in_valid = 1'b0;
    check("lat_pre_bit_valid", bit_valid, 0);
    check("hold_full_ready", in_ready, 0);
    check("hold_full_busy", busy, 1);
    @(posedge clk);
    #1;
    check("lat_msb_valid", bit_valid, 1);
    check("lat_msb_bit", bit_out, 1);
    check("lat_msb_fs", frame_start, 1);
    check("ready_after_xfer", in_ready, 1);
    drain();
    check("b0_run", max_run, FRAME);
    check("b0_detect_1011", det_hit, 1);
    check("b0_bits", bits_seen, FRAME);

    // A5 then 3C with in_valid held high
    clear_stats();
    send(8'hA5);
    check("a5_hold_ready", in_ready, 0);
    send(8'h3C);
    check("3c_hold_ready", in_ready, 0);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("3c_still_held", in_ready, 0);
    end
    drain();
    check("a5_3c_run", max_run, 2 * FRAME);
    check("a5_3c_bits", bits_seen, 2 * FRAME);

    // Sustained random stream
    clear_stats();
    for (int i = 0; i < 6; i++) begin
      send(WIDTH'($urandom));
    end
    in_valid = 1'b0;
    drain();
    check("burst_run", max_run, 6 * FRAME);

    // Reset mid-word with another word held
    clear_stats();
    send(8'hFF);
    send(8'h81);
    in_valid = 1'b0;
    for (int n = 0; bits_seen < 3; n++) begin
      @(negedge clk);
      #1;
      if (n > 4 * FRAME) begin
        check("mid_rst_wait", bits_seen, 3);
        break;
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    reset = 1'b0;
    check("mid_rst_bit_valid", bit_valid, 0);
    check("mid_rst_bit_out", bit_out, IDLE_BIT);
    check("mid_rst_fs", frame_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    repeat (2 * FRAME) @(posedge clk);
    #1;
    check("mid_rst_no_more_bits", bits_seen, 3);

    // Reset wins over a same-cycle accept
    clear_stats();
    in_valid = 1'b1;
    in_data  = 8'hF0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst_prio_ready", in_ready, 1);
    check("rst_prio_busy", busy, 0);
    repeat (FRAME + 4) @(posedge clk);
    #1;
    check("rst_prio_no_bits", bits_seen, 0);

    // Normal operation resumes after reset
    clear_stats();
    send(8'h5A);
    in_valid = 1'b0;
    drain();
    check("post_rst_bits", bits_seen, FRAME);
    check("sb_empty_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
